fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

Round-robin arbiter that shares the write port of one FIFO instance between N_REQ requesters in the cache subsystem, such as refill, write-back and prefetch engines. Each requester is granted the port for a burst of up to MAX_BURST words. The burst ends on the requester's last-beat flag, on reaching the cap, or when the requester drops its request. The block drives the FIFO's write-enable and write-data inputs directly and respects the FIFO's full flag.

## Interface
Parameters:
- N_REQ, 4: number of requesters, 2..8.
- W_DATA, 32: data width; must equal the FIFO's W_WRITE.
- MAX_BURST, 4: maximum beats per grant, 1..16.

Ports:
- sClk_i  in  1  single clock for the block and the FIFO.
- snRst_i  in  1  reset; asynchronous, active-low.
- Req_i  in  N_REQ  per-requester request; held high while data is valid.
- Last_i  in  N_REQ  per-requester last-beat flag, qualified by Req_i.
- Data_i  in  N_REQ*W_DATA  packed data; requester i occupies bits [i*W_DATA +: W_DATA].
- Grant_o  out  N_REQ  one-hot owner indication, combinational from state.
- Ack_o  out  N_REQ  one-hot beat-accepted strobe, meaning the word is written this cycle.
- FifoFull_i  in  1  FIFO full flag.
- FifoWrite_o  out  1  FIFO write enable.
- FifoWriteData_o  out  W_DATA  FIFO write data.
- Busy_o  out  1  high in state BURST.

## Operation
- Two-state FSM: IDLE and BURST.
- Registers:
  - Owner, $clog2(N_REQ) bits.
  - RrPtr, same width: the index searched first.
  - BeatCnt, $clog2(MAX_BURST+1) bits.
- IDLE:
  - If any Req_i is high, pick the first set bit starting at RrPtr and scanning upward with modulo-N_REQ wrap.
  - Load Owner, clear BeatCnt, and go to BURST.
  - If no Req_i is high, stay in IDLE.
- BURST:
  - Grant_o = onehot(Owner).
  - A beat occurs when Req_i[Owner] & ~FifoFull_i.
  - On a beat: FifoWrite_o=1, Ack_o[Owner]=1, FifoWriteData_o = Data_i slice[Owner], BeatCnt increments.
- The burst ends, returning to IDLE with RrPtr <= Owner+1 mod N_REQ, on any of:
  - a beat with Last_i[Owner]=1;
  - a beat that brings BeatCnt to MAX_BURST;
  - Req_i[Owner]=0, which is an abandon with no write that cycle.
- FifoFull_i high in BURST: no write, no Ack, hold state and BeatCnt, no timeout.
- FifoWriteData_o is zero whenever FifoWrite_o=0.
- Requesters must not change Data_i/Last_i while Req_i is high and Ack_o is low.

## Timing
- Reset values: state IDLE, Owner 0, RrPtr 0, BeatCnt 0. All outputs 0: Grant_o, Ack_o, FifoWrite_o, FifoWriteData_o, Busy_o.
- Arbitration latency: Req_i rising in cycle t gives Grant_o and the first possible write in cycle t+1.
- Every burst ends with exactly one IDLE cycle, so the FIFO sees at most MAX_BURST writes per MAX_BURST+1 cycles.
- Write data path is combinational from Data_i to FifoWriteData_o. FifoWrite_o is combinational from FifoFull_i and Req_i.
- Reset asserted mid-burst: immediate return to reset values; the partial burst is lost and it is the requester's job to retry.

## Configuration
- FIFO_ARB_PRIO_EN defined: requester 0 is fixed high priority. In IDLE, Req_i[0]=1 always wins regardless of RrPtr. Requesters 1..N_REQ-1 rotate among themselves, and RrPtr is not updated after a requester-0 burst.
- FIFO_ARB_PRIO_EN undefined: pure round-robin as described in Operation.

## Structure
- Shared package holds:
  - the FSM state encoding: IDLE=1'b0, BURST=1'b1;
  - a function computing the rotating first-set-bit index, reused by future read-side arbiters.
- One sub-module, rr_pick: combinational, takes (Req vector, RrPtr) and returns (index, found). It is instantiated once.

## Test plan
- Reset, then Req_i=4'b0000 for 10 cycles -> all outputs stay 0, Busy_o=0.
- Req_i=4'b0110 held, Last_i=0, MAX_BURST=4 -> requester 1 gets 4 writes. After one IDLE cycle, requester 2 gets 4 writes, then requester 1 again.
- Requester 3 alone, Last_i[3]=1 on beat 2 -> exactly 2 FIFO writes with Data_i slice 3, then IDLE and RrPtr=0.
- FifoFull_i high for 5 cycles mid-burst -> FifoWrite_o and Ack_o are 0 throughout; the burst resumes afterwards with BeatCnt preserved and total writes equal to 4.
- Owner drops Req_i after 1 beat -> no write that cycle, IDLE next cycle, next requester granted.
- With FIFO_ARB_PRIO_EN: Req_i=4'b1001 continuously -> requester 0 wins every arbitration. Without the macro -> grants alternate 0, 3, 0, 3.

Source files
------------

// File: rtl/fifo_write_arbiter_pkg.sv
// Shared arbitration types and the rotating first-set-bit search used by
// the FIFO write arbiter (and intended for future read-side arbiters).
package fifo_write_arbiter_pkg;

  localparam int unsigned RR_MAX_REQ = 8;
  localparam int unsigned RR_IDX_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req[n_req-1:0], starting at ptr and wrapping modulo n_req.
  function automatic rr_pick_t rr_first_set(
    input logic [RR_MAX_REQ-1:0] req,
    input int unsigned           n_req,
    input logic [RR_IDX_W-1:0]   ptr
  );
    rr_pick_t          res;
    logic [RR_IDX_W:0] j;
    res = '0;
    for (int unsigned k = 0; k < RR_MAX_REQ; k++) begin
      j = {1'b0, ptr} + (RR_IDX_W+1)'(k);
      if (j >= (RR_IDX_W+1)'(n_req)) j = j - (RR_IDX_W+1)'(n_req);
      if ((k < n_req) && !res.found && req[j[RR_IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = j[RR_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational rotating pick: first requester at or after rr_ptr, with wrap.
module fifo_write_arbiter_rr_pick
  import fifo_write_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] idx_c,
  output logic             found_c
);

  rr_pick_t pick;

  always_comb begin
    pick = rr_first_set(RR_MAX_REQ'(req), N_REQ, RR_IDX_W'(rr_ptr));
  end

  // Range guard keeps the narrowed index meaningful for any N_REQ.
  assign found_c = pick.found & (32'(pick.idx) < N_REQ);
  assign idx_c   = IDX_W'(pick.idx);

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among N_REQ requesters.
// Optional FIFO_ARB_PRIO_EN: requester 0 always wins arbitration, others rotate.
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned W_DATA    = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                    sClk_i,
  input  logic                    snRst_i,
  input  logic [N_REQ-1:0]        Req_i,
  input  logic [N_REQ-1:0]        Last_i,
  input  logic [N_REQ*W_DATA-1:0] Data_i,
  output logic [N_REQ-1:0]        Grant_o,
  output logic [N_REQ-1:0]        Ack_o,
  input  logic                    FifoFull_i,
  output logic                    FifoWrite_o,
  output logic [W_DATA-1:0]       FifoWriteData_o,
  output logic                    Busy_o
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [N_REQ-1:0]  pick_req;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_found;
  logic [IDX_W-1:0]  ptr_after;
  logic [CNT_W-1:0]  cnt_inc;
  logic [N_REQ-1:0]  grant_c;
  logic [W_DATA-1:0] data_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign data_arr[g] = Data_i[g*W_DATA +: W_DATA];
  end

`ifdef FIFO_ARB_PRIO_EN
  // Requester 0 bypasses the rotation; the rest rotate among themselves.
  assign pick_req  = Req_i & ~N_REQ'(1);
  assign arb_found = Req_i[0] | pick_found;
  assign arb_idx   = Req_i[0] ? '0 : pick_idx;
  assign ptr_after = (owner_q == '0) ? rr_ptr_q :
                     (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
`else
  assign pick_req  = Req_i;
  assign arb_found = pick_found;
  assign arb_idx   = pick_idx;
  assign ptr_after = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
`endif

  fifo_write_arbiter_rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req     (pick_req),
    .rr_ptr  (rr_ptr_q),
    .idx_c   (pick_idx),
    .found_c (pick_found)
  );

  assign cnt_inc = beat_cnt_q + CNT_W'(1);
  assign grant_c = N_REQ'(1) << owner_q;

  // State register.
  always_ff @(posedge sClk_i or negedge snRst_i) begin
    if (!snRst_i) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Next-state and port outputs; a full FIFO simply stalls the burst.
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    rr_ptr_d        = rr_ptr_q;
    beat_cnt_d      = beat_cnt_q;
    Grant_o         = '0;
    Ack_o           = '0;
    FifoWrite_o     = 1'b0;
    FifoWriteData_o = '0;
    Busy_o          = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          state_d    = BURST;
          owner_d    = arb_idx;
          beat_cnt_d = '0;
        end
      end
      BURST: begin
        Busy_o  = 1'b1;
        Grant_o = grant_c;
        if (!Req_i[owner_q]) begin
          state_d  = IDLE;
          rr_ptr_d = ptr_after;
        end else if (!FifoFull_i) begin
          FifoWrite_o     = 1'b1;
          Ack_o           = grant_c;
          FifoWriteData_o = data_arr[owner_q];
          beat_cnt_d      = cnt_inc;
          if (Last_i[owner_q] || (cnt_inc == CNT_W'(MAX_BURST))) begin
            state_d  = IDLE;
            rr_ptr_d = ptr_after;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios plus randomized requesters,
// all checked cycle by cycle against a behavioural arbitration model.
module tb_fifo_write_arbiter;

  localparam int unsigned N_REQ     = 4;
  localparam int unsigned W_DATA    = 32;
  localparam int unsigned MAX_BURST = 4;

  logic                    sClk_i = 1'b0;
  logic                    snRst_i;
  logic [N_REQ-1:0]        Req_i;
  logic [N_REQ-1:0]        Last_i;
  logic [N_REQ*W_DATA-1:0] Data_i;
  logic [N_REQ-1:0]        Grant_o;
  logic [N_REQ-1:0]        Ack_o;
  logic                    FifoFull_i;
  logic                    FifoWrite_o;
  logic [W_DATA-1:0]       FifoWriteData_o;
  logic                    Busy_o;

  fifo_write_arbiter #(
    .N_REQ     (N_REQ),
    .W_DATA    (W_DATA),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .sClk_i          (sClk_i),
    .snRst_i         (snRst_i),
    .Req_i           (Req_i),
    .Last_i          (Last_i),
    .Data_i          (Data_i),
    .Grant_o         (Grant_o),
    .Ack_o           (Ack_o),
    .FifoFull_i      (FifoFull_i),
    .FifoWrite_o     (FifoWrite_o),
    .FifoWriteData_o (FifoWriteData_o),
    .Busy_o          (Busy_o)
  );

  always #5 sClk_i = ~sClk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: who owns the port, beats so far, where the search starts.
  bit m_busy;
  int m_owner, m_ptr, m_cnt;

  // Observations taken from the DUT ports.
  int               owners_q[$];
  int               wr_cnt[N_REQ];
  int               full_writes;
  logic [W_DATA-1:0] last_wdata;
  logic [N_REQ-1:0] prev_grant;
  logic [N_REQ-1:0] last_ack;

  int pkt_left[N_REQ];
  int gap[N_REQ];

  function automatic logic [W_DATA-1:0] slice(input int i);
    return Data_i[i*W_DATA +: W_DATA];
  endfunction

  function automatic int onehot_idx(input logic [N_REQ-1:0] v);
    for (int i = 0; i < int'(N_REQ); i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int q_at(input int i);
    if (i < owners_q.size()) return owners_q[i];
    return -1;
  endfunction

  function automatic int pick_winner();
`ifdef FIFO_ARB_PRIO_EN
    if (Req_i[0]) return 0;
`endif
    for (int k = 0; k < int'(N_REQ); k++) begin
      int j;
      j = (m_ptr + k) % int'(N_REQ);
`ifdef FIFO_ARB_PRIO_EN
      if (j == 0) continue;
`endif
      if (Req_i[j]) return j;
    end
    return -1;
  endfunction

  task automatic end_burst();
    m_busy = 1'b0;
`ifdef FIFO_ARB_PRIO_EN
    if (m_owner != 0) m_ptr = (m_owner + 1) % int'(N_REQ);
`else
    m_ptr = (m_owner + 1) % int'(N_REQ);
`endif
  endtask

  task automatic clear_log();
    owners_q.delete();
    for (int i = 0; i < int'(N_REQ); i++) wr_cnt[i] = 0;
    full_writes = 0;
  endtask

  // Compare one cycle against the model, then advance model and clock.
  task automatic tick();
    logic [N_REQ-1:0]  e_grant, e_ack;
    logic              e_wr;
    logic [W_DATA-1:0] e_data;
    int                w;
    #1;
    e_grant = '0; e_ack = '0; e_wr = 1'b0; e_data = '0;
    if (m_busy) begin
      e_grant = N_REQ'(1) << m_owner;
      if (Req_i[m_owner] && !FifoFull_i) begin
        e_wr   = 1'b1;
        e_ack  = e_grant;
        e_data = slice(m_owner);
      end
    end
    check("grant", 64'(Grant_o), 64'(e_grant));
    check("ack", 64'(Ack_o), 64'(e_ack));
    check("fifo_write", 64'(FifoWrite_o), 64'(e_wr));
    check("fifo_wdata", 64'(FifoWriteData_o), 64'(e_data));
    check("busy", 64'(Busy_o), 64'(m_busy));

    if ((Grant_o != '0) && (prev_grant == '0)) owners_q.push_back(onehot_idx(Grant_o));
    prev_grant = Grant_o;
    for (int i = 0; i < int'(N_REQ); i++) if (FifoWrite_o && Ack_o[i]) wr_cnt[i]++;
    if (FifoWrite_o && FifoFull_i) full_writes++;
    if (FifoWrite_o) last_wdata = FifoWriteData_o;
    last_ack = e_ack;

    if (!m_busy) begin
      w = pick_winner();
      if (w >= 0) begin
        m_busy  = 1'b1;
        m_owner = w;
        m_cnt   = 0;
      end
    end else if (!Req_i[m_owner]) begin
      end_burst();
    end else if (!FifoFull_i) begin
      m_cnt++;
      if (Last_i[m_owner] || (m_cnt == int'(MAX_BURST))) end_burst();
    end
    @(posedge sClk_i);
    #1;
  endtask

  // Reset asserted with whatever inputs are present; outputs must drop at once.
  task automatic do_reset();
    snRst_i = 1'b0;
    #1;
    check("rst_grant", 64'(Grant_o), 64'd0);
    check("rst_ack", 64'(Ack_o), 64'd0);
    check("rst_write", 64'(FifoWrite_o), 64'd0);
    check("rst_wdata", 64'(FifoWriteData_o), 64'd0);
    check("rst_busy", 64'(Busy_o), 64'd0);
    Req_i = '0; Last_i = '0; FifoFull_i = 1'b0;
    m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;
    prev_grant = '0; last_ack = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin pkt_left[i] = 0; gap[i] = 0; end
    @(posedge sClk_i);
    @(posedge sClk_i);
    #3 snRst_i = 1'b1;
    @(posedge sClk_i);
    #1;
  endtask

  // Random requesters: hold data/last until acked, occasionally abandon.
  task automatic agents_step();
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (Req_i[i]) begin
        if (last_ack[i]) begin
          pkt_left[i]--;
          if (pkt_left[i] == 0) begin
            Req_i[i] = 1'b0;
            gap[i]   = int'($urandom_range(0, 3));
          end else begin
            Data_i[i*W_DATA +: W_DATA] = W_DATA'($urandom);
          end
        end else if ($urandom_range(0, 39) == 0) begin
          Req_i[i] = 1'b0;
          gap[i]   = int'($urandom_range(0, 3));
        end
      end else if (gap[i] > 0) begin
        gap[i]--;
      end else begin
        Req_i[i]    = 1'b1;
        pkt_left[i] = int'($urandom_range(1, 6));
        Data_i[i*W_DATA +: W_DATA] = W_DATA'($urandom);
      end
      Last_i[i] = Req_i[i] && (pkt_left[i] == 1);
    end
    FifoFull_i = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    int exp_f[4];
    Req_i = '0; Last_i = '0; FifoFull_i = 1'b0; Data_i = '0;
    do_reset();

    // No requests: nothing moves.
    clear_log();
    repeat (10) tick();
    check("idle_writes", 64'(wr_cnt[0] + wr_cnt[1] + wr_cnt[2] + wr_cnt[3]), 64'd0);
    check("idle_grants", 64'(owners_q.size()), 64'd0);

    // Two steady requesters share in full-length bursts.
    do_reset();
    clear_log();
    for (int i = 0; i < int'(N_REQ); i++) Data_i[i*W_DATA +: W_DATA] = W_DATA'(32'hA5A5_0000 + i);
    Req_i = 4'b0110;
    repeat (15) tick();
    check("b_bursts", 64'(owners_q.size()), 64'd3);
    check("b_owner0", 64'(q_at(0)), 64'd1);
    check("b_owner1", 64'(q_at(1)), 64'd2);
    check("b_owner2", 64'(q_at(2)), 64'd1);
    check("b_wr1", 64'(wr_cnt[1]), 64'd8);
    check("b_wr2", 64'(wr_cnt[2]), 64'd4);

    // Last on beat 2 ends the burst; pointer wraps to 0.
    do_reset();
    clear_log();
    Data_i[3*W_DATA +: W_DATA] = W_DATA'(32'hC0DE_0003);
    Req_i = 4'b1000;
    tick();
    tick();
    Last_i[3] = 1'b1;
    tick();
    check("c_data", 64'(last_wdata), 64'h0000_0000_C0DE_0003);
    Req_i = 4'b1001; Last_i = 4'b1001;
    tick();
    tick();
    check("c_wr3", 64'(wr_cnt[3]), 64'd2);
    check("c_next_owner", 64'(q_at(1)), 64'd0);

    // Full FIFO stalls mid-burst without losing the beat count.
    do_reset();
    clear_log();
    Req_i = 4'b0100;
    tick();
    tick();
    FifoFull_i = 1'b1;
    repeat (5) tick();
    FifoFull_i = 1'b0;
    repeat (4) tick();
    check("d_wr2", 64'(wr_cnt[2]), 64'd4);
    check("d_full_writes", 64'(full_writes), 64'd0);

    // Owner abandons after one beat; next requester takes over.
    do_reset();
    clear_log();
    Req_i = 4'b0110;
    tick();
    tick();
    Req_i[1] = 1'b0;
    repeat (3) tick();
    check("e_wr1", 64'(wr_cnt[1]), 64'd1);
    check("e_next_owner", 64'(q_at(1)), 64'd2);

    // Requesters 0 and 3 competing with single-beat bursts.
    do_reset();
    clear_log();
    Req_i = 4'b1001; Last_i = 4'b1001;
    repeat (8) tick();
`ifdef FIFO_ARB_PRIO_EN
    exp_f = '{0, 0, 0, 0};
`else
    exp_f = '{0, 3, 0, 3};
`endif
    check("f_bursts", 64'(owners_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) check("f_owner", 64'(q_at(i)), 64'(exp_f[i]));

    // Randomized traffic, with a reset dropped into the middle.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      agents_step();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
